// File: rtl/fetch_arbiter_pkg.sv
// Shared types for the program-memory fetch arbiter.
// Holds the FSM state encoding and the saturating counter helper.
package gpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        RELAY,
        RELEASE
    } fetch_arb_state_t;

    localparam int CNT_BITS = 16;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    function automatic logic [CNT_BITS-1:0] sat_add(
        input logic [CNT_BITS-1:0] a,
        input logic [CNT_BITS-1:0] b
    );
        logic [CNT_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_BITS] ? CNT_MAX : s[CNT_BITS-1:0];
    endfunction

endpackage

// File: rtl/fetch_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr.
// Shared with the data-memory controller.
module rr_arbiter #(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          grant_valid,
    output logic [PW-1:0] grant_idx
);

    int w_idx;

    // Scan from farthest to nearest so the nearest hit is written last.
    always_comb begin
        w_idx       = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = (int'(ptr) + k) % N;
            if (req[w_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = PW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/fetch_arbiter.sv
// Shares one program-memory read port among several fetchers, round-robin,
// optionally answering every same-address requester from one read.
module fetch_arbiter
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 2,
    parameter int COALESCE      = 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    output logic                                     mem_read_valid,
    output logic [ADDR_BITS-1:0]                     mem_read_address,
    input  logic                                     mem_read_ready,
    input  logic [DATA_BITS-1:0]                     mem_read_data,
    output logic [CNT_BITS-1:0]                      coalesce_count
);

    localparam int N  = NUM_CONSUMERS;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    fetch_arb_state_t r_state;
    fetch_arb_state_t w_next;

    logic [PW-1:0]                r_rr_ptr;
    logic [PW-1:0]                r_winner;
    logic [ADDR_BITS-1:0]         r_addr;
    logic                         r_mem_valid;
    logic [N-1:0]                 r_mask;
    logic [N-1:0]                 r_ready;
    logic [N-1:0][DATA_BITS-1:0]  r_cdata;
    logic [CNT_BITS-1:0]          r_count;

    logic                         w_grant_valid;
    logic [PW-1:0]                w_grant_idx;
    logic [N-1:0]                 w_mask;
    logic [CNT_BITS-1:0]          w_extra;

    rr_arbiter #(.N(N)) u_rr (
        .req         (consumer_read_valid),
        .ptr         (r_rr_ptr),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            if (COALESCE != 0) begin
                w_mask[i] = consumer_read_valid[i] &&
                            (consumer_read_address[i] == r_addr);
            end else begin
                w_mask[i] = consumer_read_valid[i] &&
                            (PW'(i) == r_winner);
            end
        end
    end

    // Mask is never empty when this is used, so the subtract cannot wrap.
    assign w_extra = CNT_BITS'($countones(r_mask)) - CNT_BITS'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_grant_valid) w_next = READ_WAIT;
            end
            READ_WAIT: begin
                if (mem_read_ready) w_next = RELAY;
            end
            RELAY: begin
                w_next = RELEASE;
            end
            RELEASE: begin
                if ((consumer_read_valid & r_mask) == '0) w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr    <= '0;
            r_winner    <= '0;
            r_addr      <= '0;
            r_mem_valid <= 1'b0;
            r_mask      <= '0;
            r_ready     <= '0;
            r_cdata     <= '0;
            r_count     <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_winner    <= w_grant_idx;
                        r_addr      <= consumer_read_address[w_grant_idx];
                        r_mem_valid <= 1'b1;
                    end
                end
                READ_WAIT: begin
                    if (mem_read_ready) begin
                        r_mem_valid <= 1'b0;
                        r_mask      <= w_mask;
                        r_ready     <= w_mask;
                        for (int i = 0; i < N; i++) begin
                            if (w_mask[i]) r_cdata[i] <= mem_read_data;
                        end
                    end
                end
                RELAY: begin
                    r_ready <= '0;
                    if (|r_mask) r_count <= sat_add(r_count, w_extra);
                    r_rr_ptr <= (r_winner == PW'(N - 1)) ? '0
                                                         : r_winner + PW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_read_valid      = r_mem_valid;
    assign mem_read_address    = r_addr;
    assign consumer_read_ready = r_ready;
    assign consumer_read_data  = r_cdata;
    assign coalesce_count      = r_count;

endmodule

// File: tb/tb_fetch_arbiter.sv
// Directed bench for fetch_arbiter: one coalescing and one
// non-coalescing instance sharing clock and reset.
module tb_fetch_arbiter;

    logic clk;
    logic reset;

    logic [1:0]        c_valid;
    logic [1:0][7:0]   c_addr;
    logic [1:0]        c_ready;
    logic [1:0][15:0]  c_rdata;
    logic              c_mvalid;
    logic [7:0]        c_maddr;
    logic              c_mready;
    logic [15:0]       c_mdata;
    logic [15:0]       c_count;

    logic [1:0]        n_valid;
    logic [1:0][7:0]   n_addr;
    logic [1:0]        n_ready;
    logic [1:0][15:0]  n_rdata;
    logic              n_mvalid;
    logic [7:0]        n_maddr;
    logic              n_mready;
    logic [15:0]       n_mdata;
    logic [15:0]       n_count;

    int n_pass;
    int n_chk;
    int hi;

    fetch_arbiter #(
        .ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(2), .COALESCE(1)
    ) dut_c (
        .clk                   (clk),
        .reset                 (reset),
        .consumer_read_valid   (c_valid),
        .consumer_read_address (c_addr),
        .consumer_read_ready   (c_ready),
        .consumer_read_data    (c_rdata),
        .mem_read_valid        (c_mvalid),
        .mem_read_address      (c_maddr),
        .mem_read_ready        (c_mready),
        .mem_read_data         (c_mdata),
        .coalesce_count        (c_count)
    );

    fetch_arbiter #(
        .ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(2), .COALESCE(0)
    ) dut_n (
        .clk                   (clk),
        .reset                 (reset),
        .consumer_read_valid   (n_valid),
        .consumer_read_address (n_addr),
        .consumer_read_ready   (n_ready),
        .consumer_read_data    (n_rdata),
        .mem_read_valid        (n_mvalid),
        .mem_read_address      (n_maddr),
        .mem_read_ready        (n_mready),
        .mem_read_data         (n_mdata),
        .coalesce_count        (n_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        n_pass   = 0;
        n_chk    = 0;
        reset    = 1'b0;
        c_valid  = 2'b11;
        c_addr[0] = 8'h30;
        c_addr[1] = 8'h31;
        c_mready = 1'b0;
        c_mdata  = 16'h0;
        n_valid  = 2'b00;
        n_addr[0] = 8'h04;
        n_addr[1] = 8'h08;
        n_mready = 1'b0;
        n_mdata  = 16'h0;

        // 1: reset holds everything at zero, then core0 wins
        repeat (3) tick();
        chk("rst_mvalid", 32'(c_mvalid), 32'h0);
        chk("rst_ready", 32'(c_ready), 32'h0);
        chk("rst_count", 32'(c_count), 32'h0);
        chk("rst_maddr", 32'(c_maddr), 32'h0);
        chk("rst_rdata", 32'(c_rdata), 32'h0);
        reset = 1'b1;
        tick();
        chk("rst_grant_mv", 32'(c_mvalid), 32'h1);
        chk("rst_grant_addr", 32'(c_maddr), 32'h30);
        c_mready = 1'b1;
        c_mdata  = 16'h5555;
        tick();
        c_mready = 1'b0;
        chk("rst_relay_ready", 32'(c_ready), 32'h1);
        chk("rst_relay_data0", 32'(c_rdata[0]), 32'h5555);
        chk("rst_relay_mv", 32'(c_mvalid), 32'h0);
        c_valid = 2'b00;
        tick();
        tick();
        chk("rst_idle_ready", 32'(c_ready), 32'h0);

        // 2: single fetch, memory answers after two wait cycles
        c_valid   = 2'b01;
        c_addr[0] = 8'h10;
        hi = 0;
        tick();
        hi += int'(c_mvalid);
        chk("sf_addr", 32'(c_maddr), 32'h10);
        tick();
        hi += int'(c_mvalid);
        tick();
        hi += int'(c_mvalid);
        c_mready = 1'b1;
        c_mdata  = 16'hBEEF;
        tick();
        hi += int'(c_mvalid);
        c_mready = 1'b0;
        chk("sf_ready", 32'(c_ready), 32'h1);
        chk("sf_data0", 32'(c_rdata[0]), 32'hBEEF);
        chk("sf_mv_cycles", 32'(hi), 32'd3);
        c_valid = 2'b00;
        tick();
        chk("sf_pulse_end", 32'(c_ready), 32'h0);
        chk("sf_data_hold", 32'(c_rdata[0]), 32'hBEEF);
        tick();

        // 3: round robin without coalescing, grants 0,1,0,1
        n_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_mv", 32'(n_mvalid), 32'h1);
            chk("rr_addr", 32'(n_maddr), (k % 2 == 0) ? 32'h04 : 32'h08);
            n_mready = 1'b1;
            n_mdata  = 16'hA000 + 16'(k);
            tick();
            n_mready = 1'b0;
            chk("rr_ready", 32'(n_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_data", 32'(n_rdata[k % 2]), 32'hA000 + 32'(k));
            n_valid[k % 2] = 1'b0;
            tick();
            tick();
            n_valid[k % 2] = 1'b1;
        end
        n_valid = 2'b00;
        chk("rr_count", 32'(n_count), 32'h0);

        // 4: coalescing, both at 0x20, one transaction serves both
        c_valid   = 2'b11;
        c_addr[0] = 8'h20;
        c_addr[1] = 8'h20;
        tick();
        chk("co_mv", 32'(c_mvalid), 32'h1);
        chk("co_addr", 32'(c_maddr), 32'h20);
        c_mready = 1'b1;
        c_mdata  = 16'h1234;
        tick();
        c_mready = 1'b0;
        chk("co_ready", 32'(c_ready), 32'h3);
        chk("co_data0", 32'(c_rdata[0]), 32'h1234);
        chk("co_data1", 32'(c_rdata[1]), 32'h1234);
        c_valid = 2'b00;
        tick();
        chk("co_count", 32'(c_count), 32'h1);
        chk("co_single_txn", 32'(c_mvalid), 32'h0);
        tick();

        // 5: winner drops valid while waiting -> empty relay
        c_valid   = 2'b01;
        c_addr[0] = 8'h40;
        tick();
        chk("dr_mv", 32'(c_mvalid), 32'h1);
        c_valid = 2'b00;
        tick();
        c_mready = 1'b1;
        c_mdata  = 16'h7777;
        tick();
        c_mready = 1'b0;
        chk("dr_no_ready", 32'(c_ready), 32'h0);
        chk("dr_mv_drop", 32'(c_mvalid), 32'h0);
        chk("dr_data_kept", 32'(c_rdata[0]), 32'h1234);
        tick();
        tick();
        chk("dr_count", 32'(c_count), 32'h1);
        c_valid   = 2'b11;
        c_addr[0] = 8'h50;
        c_addr[1] = 8'h60;
        tick();
        chk("dr_next_grant", 32'(c_maddr), 32'h60);
        c_mready = 1'b1;
        c_mdata  = 16'h6666;
        tick();
        c_mready = 1'b0;
        chk("dr_next_ready", 32'(c_ready), 32'h2);
        chk("dr_next_data1", 32'(c_rdata[1]), 32'h6666);
        c_valid = 2'b00;
        tick();
        tick();

        // 6: async reset in READ_WAIT, late response ignored
        c_valid   = 2'b01;
        c_addr[0] = 8'h70;
        tick();
        chk("ar_mv", 32'(c_mvalid), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_async_drop", 32'(c_mvalid), 32'h0);
        c_valid = 2'b00;
        tick();
        reset    = 1'b1;
        c_mready = 1'b1;
        c_mdata  = 16'h9999;
        tick();
        c_mready = 1'b0;
        chk("ar_late_ready", 32'(c_ready), 32'h0);
        chk("ar_late_mv", 32'(c_mvalid), 32'h0);
        tick();
        chk("ar_late_ready2", 32'(c_ready), 32'h0);
        chk("ar_data_clear", 32'(c_rdata), 32'h0);
        chk("ar_count_clear", 32'(c_count), 32'h0);
        c_valid   = 2'b10;
        c_addr[1] = 8'h80;
        tick();
        chk("ar_idle_grant", 32'(c_mvalid), 32'h1);
        chk("ar_idle_addr", 32'(c_maddr), 32'h80);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
